dtw_ref_loader: RTL and testbench
=================================

# dtw_ref_loader

Streaming loader that fills the DTW reference-sequence BRAM before alignment starts. It accepts packed reference samples over an AXI4-Stream slave and unpacks each beat into per-sample writes. It drives the memory's write port (wen/addr/din) with a monotonically increasing address, counts the samples written, and checks stream framing against the programmed length. It sits directly upstream of the reference memory, between the host DMA stream and the DTW core.

## Interface
- width, 16, sample width in bits
- ptrWid, 18, memory address width; capacity 2**ptrWid samples
- dataWid, 64, stream beat width; lanes = dataWid/width (must divide exactly, lanes ≥ 2)
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load (ignored unless idle)
- ref_len  in  ptrWid+1  number of samples to load; sampled on start
- s_axis_tdata  in  dataWid  packed samples, lane 0 in bits [width-1:0]
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat ready
- s_axis_tlast  in  1  final beat of the reference frame
- mem_wen  out  1  write enable to reference memory port A
- mem_addr  out  ptrWid  write address
- mem_din  out  width  write data
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky framing/length error; cleared on next accepted start
- loaded_len  out  ptrWid+1  samples written by last load; held until next start

## Operation
- States: IDLE, ACCEPT, WRITE, DRAIN, FIN.
- IDLE: tready=0. On start: latch ref_len, clear addr counter, sample counter, lane counter, err, loaded_len. If ref_len==0 or ref_len>2**ptrWid → set err if >2**ptrWid, go FIN with no writes. Else go ACCEPT.
- ACCEPT: tready=1. On tvalid&tready: latch tdata and tlast into beat buffer, go WRITE.
- WRITE: tready=0; one sample per cycle, lane 0 first: mem_wen=1, mem_addr=addr counter, mem_din=lane. Increment addr, sample count, lane.
  - Sample count reaches ref_len: stop (remaining lanes of the beat discarded). If buffered tlast=1 → FIN; else set err, go DRAIN.
  - Last lane written, count < ref_len: if buffered tlast=1 → set err (short frame), go FIN; else → ACCEPT.
- DRAIN: tready=1, no writes; discard beats until a beat with tlast accepted, then FIN.
- FIN: done=1 for one cycle, busy=0 afterward, loaded_len = sample count; → IDLE.
- start while not IDLE is ignored. ref_len changes after start have no effect.
- Address never wraps: ref_len ≤ 2**ptrWid guarantees the last address is 2**ptrWid−1 at most.
- Reset mid-operation: return to IDLE in the next cycle; memory contents already written are left as is; no done pulse.

## Timing
- Reset values: s_axis_tready=0, mem_wen=0, mem_addr=0, mem_din=0, busy=0, done=0, err=0, loaded_len=0.
- mem_wen, mem_addr, mem_din are registered.
- start at cycle 0 → busy=1 and tready=1 from cycle 1.
- Beat handshake at cycle k → mem_wen high in cycles k+1..k+lanes (fewer if length is reached first). tready is high again at cycle k+lanes+1.
- Sustained throughput: lanes samples per lanes+1 cycles.
- Final write at cycle n → done=1 at cycle n+1, busy=0 at n+2.
- Zero-length or oversized start at cycle 0 → done at cycle 2, with no mem_wen.
- err asserts in the same cycle the FSM enters DRAIN or FIN for the error case, and stays high until the next accepted start.

## Test plan
- Nominal, lanes=4: ref_len=8; two beats 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005 (tlast on second), tvalid always high → mem writes addr 0..7 with data 1..8; done one cycle after addr 7; loaded_len=8; err=0.
- Partial final beat: ref_len=6; two beats, tlast on second → writes addr 0..5 only; lanes 6,7 never written; done=1, err=0.
- Backpressure/bubbles: ref_len=12; tvalid toggles randomly → same memory image as an ungapped run; tready never high during WRITE; no write while tvalid is low in ACCEPT.
- Framing errors:
  - ref_len=8 with tlast on beat 1 → 4 writes, err=1, loaded_len=4.
  - ref_len=4 with tlast on beat 3 → 4 writes, beats 2–3 drained with no writes, err=1, done after the tlast beat.
- Edge lengths:
  - ref_len=0 → done at cycle 2, no writes.
  - ref_len=2**ptrWid+1 → err=1, no writes.
  - ref_len=2**ptrWid (small ptrWid in the bench) → last write at addr 2**ptrWid−1.
- Reset/start abuse: assert rst during WRITE → all outputs return to reset values next cycle, no done. A second start during busy is ignored, and the original load completes unchanged.

Source files
------------

// File: rtl/dtw_ref_loader_if.sv
// Purpose : AXI4-Stream beat channel carrying packed reference samples from
//           the host DMA into dtw_ref_loader.
// Signals : tdata  - packed samples, lane 0 in the low bits
//           tvalid - beat valid (master -> slave)
//           tready - beat ready (slave -> master)
//           tlast  - final beat of the reference frame
interface dtw_ref_loader_if #(
    parameter int unsigned DATA_WID = 64
);
    logic [DATA_WID-1:0] tdata;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dtw_ref_loader.sv
// Purpose : Fills the DTW reference BRAM from a packed AXI4-Stream. Each
//           accepted beat is unpacked into one memory write per cycle
//           (lane 0 first) at a monotonically increasing address, and the
//           stream framing (tlast) is checked against the programmed length.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           i_start         - one-cycle pulse, honoured only when idle
//           i_ref_len       - samples to load, sampled on accepted start
//           s_axis          - stream slave (tdata/tvalid/tready/tlast)
//           o_mem_wen/addr/din - registered write port to reference memory
//           o_busy          - load in progress
//           o_done          - one-cycle completion pulse
//           o_err           - sticky framing/length error
//           o_loaded_len    - samples written by the last load
module dtw_ref_loader #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PTR_WID  = 18,
    parameter int unsigned DATA_WID = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [PTR_WID:0]    i_ref_len,
    dtw_ref_loader_if.slave     s_axis,
    output logic                o_mem_wen,
    output logic [PTR_WID-1:0]  o_mem_addr,
    output logic [WIDTH-1:0]    o_mem_din,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [PTR_WID:0]    o_loaded_len
);
    localparam int unsigned LANES  = DATA_WID / WIDTH;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_W  = PTR_WID + 1;
    localparam logic [CNT_W-1:0] CAP = {1'b1, {PTR_WID{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DRAIN,
        FIN
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                        r_tready;
    logic                        r_mem_wen;
    logic [PTR_WID-1:0]          r_mem_addr;
    logic [WIDTH-1:0]            r_mem_din;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_err;
    logic [CNT_W-1:0]            r_loaded_len;
    logic [CNT_W-1:0]            r_len;
    logic [CNT_W-1:0]            r_cnt;
    logic [LANE_W-1:0]           r_lane;
    logic [LANES-1:0][WIDTH-1:0] r_beat;
    logic                        r_last;
    logic                        r_skip;

    logic                        w_load;
    logic                        w_launch;
    logic                        w_first;
    logic                        w_set_err;
    logic                        w_done_next;
    logic                        w_fin_len;
    logic                        w_skip_next;
    logic                        w_hs;
    logic                        w_len_hit;
    logic                        w_last_lane;
    logic [LANE_W-1:0]           w_lane_next;
    logic [LANES-1:0][WIDTH-1:0] w_src;

    // r_cnt counts writes including the one currently on the memory port.
    assign w_hs        = s_axis.tvalid && r_tready;
    assign w_len_hit   = (r_cnt == r_len);
    assign w_last_lane = (r_lane == LANE_W'(LANES - 1));

    // Next lane to present: lane 0 of a freshly accepted beat, else the next buffered lane.
    always_comb begin
        w_lane_next = LANE_W'(r_lane + LANE_W'(1));
        w_src       = r_beat;
        if (w_first) begin
            w_lane_next = '0;
            w_src       = s_axis.tdata;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_launch     = 1'b0;
        w_first      = 1'b0;
        w_set_err    = 1'b0;
        w_done_next  = 1'b0;
        w_fin_len    = 1'b0;
        w_skip_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    if ((i_ref_len == '0) || (i_ref_len > CAP)) begin
                        // Rejected lengths linger one extra cycle in FIN before done.
                        w_state_next = FIN;
                        w_set_err    = (i_ref_len > CAP);
                        w_skip_next  = 1'b1;
                    end else begin
                        w_state_next = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                if (w_hs) begin
                    w_launch     = 1'b1;
                    w_first      = 1'b1;
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                if (w_len_hit) begin
                    if (r_last) begin
                        w_state_next = FIN;
                        w_done_next  = 1'b1;
                        w_fin_len    = 1'b1;
                    end else begin
                        w_state_next = DRAIN;
                        w_set_err    = 1'b1;
                    end
                end else if (w_last_lane) begin
                    if (r_last) begin
                        w_state_next = FIN;
                        w_set_err    = 1'b1;
                        w_done_next  = 1'b1;
                        w_fin_len    = 1'b1;
                    end else begin
                        w_state_next = ACCEPT;
                    end
                end else begin
                    w_launch = 1'b1;
                end
            end
            DRAIN: begin
                if (w_hs && s_axis.tlast) begin
                    w_state_next = FIN;
                    w_done_next  = 1'b1;
                    w_fin_len    = 1'b1;
                end
            end
            FIN: begin
                if (r_skip) begin
                    w_done_next = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tready     <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_loaded_len <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_lane       <= '0;
            r_beat       <= '0;
            r_last       <= 1'b0;
            r_skip       <= 1'b0;
        end else begin
            r_tready  <= (w_state_next == ACCEPT) || (w_state_next == DRAIN);
            r_busy    <= (w_state_next != IDLE);
            r_done    <= w_done_next;
            r_skip    <= w_skip_next;
            r_mem_wen <= w_launch;

            if (w_load) begin
                r_len        <= i_ref_len;
                r_cnt        <= '0;
                r_lane       <= '0;
                r_loaded_len <= '0;
                r_err        <= w_set_err;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end

            if (w_first) begin
                r_beat <= s_axis.tdata;
                r_last <= s_axis.tlast;
            end

            if (w_launch) begin
                r_mem_addr <= PTR_WID'(r_cnt);
                r_mem_din  <= w_src[w_lane_next];
                r_lane     <= w_lane_next;
                r_cnt      <= CNT_W'(r_cnt + CNT_W'(1));
            end

            if (w_fin_len) begin
                r_loaded_len <= r_cnt;
            end
        end
    end

    assign s_axis.tready = r_tready;
    assign o_mem_wen     = r_mem_wen;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_din     = r_mem_din;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_loaded_len  = r_loaded_len;

endmodule

// File: tb/tb_dtw_ref_loader.sv
// Scoreboard bench for dtw_ref_loader (lanes = 4, small address space).
module tb_dtw_ref_loader;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned PTR_WID  = 4;
    localparam int unsigned DATA_WID = 64;

    logic                clk;
    logic                rst;
    logic                i_start;
    logic [PTR_WID:0]    i_ref_len;
    logic                o_mem_wen;
    logic [PTR_WID-1:0]  o_mem_addr;
    logic [WIDTH-1:0]    o_mem_din;
    logic                o_busy;
    logic                o_done;
    logic                o_err;
    logic [PTR_WID:0]    o_loaded_len;

    dtw_ref_loader_if #(.DATA_WID(DATA_WID)) axis ();

    dtw_ref_loader #(
        .WIDTH    (WIDTH),
        .PTR_WID  (PTR_WID),
        .DATA_WID (DATA_WID)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_ref_len    (i_ref_len),
        .s_axis       (axis),
        .o_mem_wen    (o_mem_wen),
        .o_mem_addr   (o_mem_addr),
        .o_mem_din    (o_mem_din),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_loaded_len (o_loaded_len)
    );

    typedef struct packed {
        logic [PTR_WID-1:0] addr;
        logic [WIDTH-1:0]   din;
    } wr_t;

    typedef struct packed {
        logic             err;
        logic [PTR_WID:0] len;
        logic             timed;
    } fin_t;

    wr_t  exp_wr[$];
    fin_t exp_fin[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_wr_cyc = -10;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Monitor: every write and every done pulse is checked against the queues.
    always @(negedge clk) begin
        wr_t  w;
        fin_t f;
        if (o_done === 1'b1) begin
            checks++;
            if (exp_fin.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done err=%0b loaded_len=%0d", o_err, o_loaded_len);
            end else begin
                f = exp_fin.pop_front();
                if (o_err !== f.err || o_loaded_len !== f.len ||
                    (f.timed && cyc != last_wr_cyc + 1)) begin
                    errors++;
                    $display("FAIL done actual err=%0b len=%0d gap=%0d expected err=%0b len=%0d gap=1",
                             o_err, o_loaded_len, cyc - last_wr_cyc, f.err, f.len);
                end
            end
        end
        if (o_mem_wen === 1'b1) begin
            checks++;
            last_wr_cyc = cyc;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d din=%h", o_mem_addr, o_mem_din);
            end else begin
                w = exp_wr.pop_front();
                if (o_mem_addr !== w.addr || o_mem_din !== w.din || axis.tready !== 1'b0) begin
                    errors++;
                    $display("FAIL write actual addr=%0d din=%h tready=%b expected addr=%0d din=%h tready=0",
                             o_mem_addr, o_mem_din, axis.tready, w.addr, w.din);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] b);
        return {16'(b + 16'd3), 16'(b + 16'd2), 16'(b + 16'd1), b};
    endfunction

    task automatic exp_writes(input int n, input logic [15:0] base);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = PTR_WID'(i);
            w.din  = 16'(base + 16'(i));
            exp_wr.push_back(w);
        end
    endtask

    task automatic push_fin(input logic e, input logic [PTR_WID:0] len, input logic timed);
        fin_t f;
        f.err   = e;
        f.len   = len;
        f.timed = timed;
        exp_fin.push_back(f);
    endtask

    task automatic do_start(input logic [PTR_WID:0] len);
        i_start   = 1'b1;
        i_ref_len = len;
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        i_ref_len = '0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l, input int gap);
        int n;
        n = 0;
        axis.tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        axis.tdata  = d;
        axis.tlast  = l;
        axis.tvalid = 1'b1;
        while (axis.tready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL beat_accept timeout tready=%b expected=1", axis.tready);
        end else begin
            @(posedge clk);
            #1;
        end
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (o_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout actual=%b expected=1", name, o_done);
        end else begin
            chk({name, "_busy_at_done"}, o_busy, 1);
            @(negedge clk);
            chk({name, "_busy_after"}, o_busy, 0);
        end
        chk({name, "_writes_left"}, exp_wr.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tready"}, axis.tready, 0);
        chk({tag, "_wen"},    o_mem_wen, 0);
        chk({tag, "_addr"},   o_mem_addr, 0);
        chk({tag, "_din"},    o_mem_din, 0);
        chk({tag, "_busy"},   o_busy, 0);
        chk({tag, "_done"},   o_done, 0);
        chk({tag, "_err"},    o_err, 0);
        chk({tag, "_loaded"}, o_loaded_len, 0);
    endtask

    task automatic wait_write_addr(input logic [PTR_WID-1:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!(o_mem_wen === 1'b1 && o_mem_addr === a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_write", o_mem_wen, 1);
    endtask

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_ref_len   = '0;
        axis.tdata  = '0;
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Nominal: two full beats, tvalid kept high.
        exp_writes(8, 16'h0001);
        push_fin(1'b0, 5'd8, 1'b1);
        do_start(5'd8);
        chk("start_tready", axis.tready, 1);
        chk("start_busy", o_busy, 1);
        send_beat(64'h0004_0003_0002_0001, 1'b0, 0);
        send_beat(64'h0008_0007_0006_0005, 1'b1, 0);
        wait_done("nominal");

        // Partial final beat: lanes 6,7 discarded.
        exp_writes(6, 16'h0011);
        push_fin(1'b0, 5'd6, 1'b1);
        do_start(5'd6);
        send_beat(mk(16'h0011), 1'b0, 0);
        send_beat(mk(16'h0015), 1'b1, 0);
        wait_done("partial");

        // Bubbles: random idle gaps before each beat.
        exp_writes(12, 16'h0021);
        push_fin(1'b0, 5'd12, 1'b1);
        do_start(5'd12);
        send_beat(mk(16'h0021), 1'b0, int'($urandom_range(0, 3)));
        send_beat(mk(16'h0025), 1'b0, int'($urandom_range(1, 4)));
        send_beat(mk(16'h0029), 1'b1, int'($urandom_range(0, 3)));
        wait_done("bubbles");

        // Short frame: tlast on beat 1 of an 8-sample load.
        exp_writes(4, 16'h0031);
        push_fin(1'b1, 5'd4, 1'b1);
        do_start(5'd8);
        send_beat(mk(16'h0031), 1'b1, 0);
        wait_done("short");

        // Long frame: length reached on beat 1, beats 2-3 drained.
        exp_writes(4, 16'h0041);
        push_fin(1'b1, 5'd4, 1'b0);
        do_start(5'd4);
        chk("long_err_cleared", o_err, 0);
        send_beat(mk(16'h0041), 1'b0, 0);
        send_beat(mk(16'h0045), 1'b0, 0);
        chk("drain_err", o_err, 1);
        chk("drain_busy", o_busy, 1);
        send_beat(mk(16'h0049), 1'b1, 0);
        chk("drain_done", o_done, 1);
        @(posedge clk);
        #1;
        chk("drain_busy_low", o_busy, 0);
        chk("drain_writes_left", exp_wr.size(), 0);

        // Zero length: done two cycles after start, no writes.
        push_fin(1'b0, 5'd0, 1'b0);
        do_start(5'd0);
        chk("zero_busy_c1", o_busy, 1);
        chk("zero_done_c1", o_done, 0);
        chk("zero_err_c1", o_err, 0);
        @(posedge clk);
        #1;
        chk("zero_done_c2", o_done, 1);
        @(posedge clk);
        #1;
        chk("zero_done_c3", o_done, 0);
        chk("zero_busy_c3", o_busy, 0);

        // Oversized length (capacity + 1).
        push_fin(1'b1, 5'd0, 1'b0);
        do_start(5'd17);
        chk("over_err_c1", o_err, 1);
        chk("over_done_c1", o_done, 0);
        @(posedge clk);
        #1;
        chk("over_done_c2", o_done, 1);
        @(posedge clk);
        #1;
        chk("over_busy_c3", o_busy, 0);

        // Full capacity: last write lands at address 15.
        exp_writes(16, 16'h0051);
        push_fin(1'b0, 5'd16, 1'b1);
        do_start(5'd16);
        send_beat(mk(16'h0051), 1'b0, 0);
        send_beat(mk(16'h0055), 1'b0, 0);
        send_beat(mk(16'h0059), 1'b0, 0);
        send_beat(mk(16'h005d), 1'b1, 0);
        wait_done("full");

        // Reset asserted during WRITE: outputs clear, no done.
        exp_writes(2, 16'h0071);
        do_start(5'd8);
        axis.tdata  = mk(16'h0071);
        axis.tlast  = 1'b0;
        axis.tvalid = 1'b1;
        wait_write_addr(4'd1);
        rst         = 1'b1;
        axis.tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_mid");
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_writes_left", exp_wr.size(), 0);
        chk("rst_idle_busy", o_busy, 0);

        // Second start while busy is ignored.
        exp_writes(4, 16'h0081);
        push_fin(1'b0, 5'd4, 1'b1);
        do_start(5'd4);
        do_start(5'd8);
        send_beat(mk(16'h0081), 1'b1, 0);
        wait_done("restart");

        repeat (3) @(posedge clk);
        #1;
        chk("fin_queue_left", exp_fin.size(), 0);
        chk("wr_queue_left", exp_wr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
